mem_except_ctrl: RTL

MEM-stage exception arbiter sitting directly upstream of cp0 and beside ctrl.
- Inputs: MEM-stage instruction exception flags, current CP0 status/cause/epc, and WB-stage CP0 writes for bypass.
- Function: selects one prioritized exception code per instruction.
- Registered outputs: excepttype/address/delay-slot to cp0; flush pulse and redirect PC to ctrl/pc_reg.
- Squashes the single in-flight younger instruction after each taken exception.

---
 rtl/mem_except_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_except_ctrl.sv
// mem_except_ctrl
//   MEM-stage exception arbiter. Picks one prioritised exception code for the
//   instruction in MEM and registers it toward cp0. On a taken exception it
//   raises a one-cycle flush with the redirect PC. It then discards the single
//   younger instruction that follows it into MEM.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   excepttype_i             MEM flags: [8] syscall, [9] invalid, [10] trap,
//                            [11] overflow, [12] eret
//   current_inst_addr_i      PC of the MEM instruction (0 = bubble)
//   is_in_delayslot_i        MEM instruction sits in a delay slot
//   cp0_status/cause/epc_i   committed cp0 register values
//   wb_cp0_we/waddr/data_i   WB-stage cp0 write, forwarded into detection
//   excepttype_o             registered code to cp0 (0,1,8,a,c,d,e)
//   current_inst_addr_o      registered PC to cp0
//   is_in_delayslot_o        registered delay-slot flag to cp0
//   flush_o, new_pc_o        one-cycle flush and redirect target
//   squash_o                 high while the younger MEM instruction is discarded

module mem_except_ctrl #(
  parameter int              DW         = 32,
  parameter logic [DW-1:0]   EXC_VECTOR = 32'h00000020
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   excepttype_i,
  input  logic [DW-1:0] current_inst_addr_i,
  input  logic          is_in_delayslot_i,
  input  logic [DW-1:0] cp0_status_i,
  input  logic [DW-1:0] cp0_cause_i,
  input  logic [DW-1:0] cp0_epc_i,
  input  logic          wb_cp0_we_i,
  input  logic [4:0]    wb_cp0_waddr_i,
  input  logic [DW-1:0] wb_cp0_data_i,
  output logic [31:0]   excepttype_o,
  output logic [DW-1:0] current_inst_addr_o,
  output logic          is_in_delayslot_o,
  output logic          flush_o,
  output logic [DW-1:0] new_pc_o,
  output logic          squash_o
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  state_t        state_q, state_d;
  logic [31:0]   excType_q, excType_d;
  logic [DW-1:0] instAddr_q, instAddr_d;
  logic          delaySlot_q, delaySlot_d;
  logic          flush_q, flush_d;
  logic [DW-1:0] newPc_q, newPc_d;

  logic [DW-1:0] statusEff;
  logic [DW-1:0] causeEff;
  logic [DW-1:0] epcEff;
  logic          intPending;
  logic [31:0]   excCode;
  logic          unusedInputs;

  // Forward a WB-stage cp0 write so detection sees the value cp0 is about to
  // commit. Only the software-writable cause bits (IP1..0, IV, WP) are taken
  // from the WB data; the rest of cause stays as cp0 currently holds it.
  always_comb begin
    statusEff = cp0_status_i;
    causeEff  = cp0_cause_i;
    epcEff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        ADDR_STATUS: statusEff = wb_cp0_data_i;
        ADDR_CAUSE: begin
          causeEff[9:8]   = wb_cp0_data_i[9:8];
          causeEff[23:22] = wb_cp0_data_i[23:22];
        end
        ADDR_EPC:    epcEff = wb_cp0_data_i;
        default:     ;
      endcase
    end
  end

  // An interrupt is taken only on a real instruction, with an enabled pending
  // line, interrupts globally enabled and not already at exception level.
  assign intPending = ((causeEff[15:8] & statusEff[15:8]) != 8'h00) &&
                      statusEff[0] && !statusEff[1] &&
                      (current_inst_addr_i != '0);

  // Priority encoder; a bubble never raises anything, whatever its flags say.
  always_comb begin
    excCode = 32'h0;
    if (current_inst_addr_i == '0)  excCode = 32'h0;
    else if (intPending)            excCode = 32'h1;
    else if (excepttype_i[8])       excCode = 32'h8;
    else if (excepttype_i[9])       excCode = 32'ha;
    else if (excepttype_i[10])      excCode = 32'hd;
    else if (excepttype_i[11])      excCode = 32'hc;
    else if (excepttype_i[12])      excCode = 32'he;
  end

  // Next-state and next-output values. In RUN the MEM instruction is passed
  // to cp0 and any exception starts a flush. In SQUASH the younger instruction
  // is dropped without being looked at, so a flush can never repeat back to
  // back.
  always_comb begin
    state_d     = RUN;
    excType_d   = 32'h0;
    instAddr_d  = '0;
    delaySlot_d = 1'b0;
    flush_d     = 1'b0;
    newPc_d     = '0;
    if (state_q == RUN) begin
      excType_d   = excCode;
      instAddr_d  = current_inst_addr_i;
      delaySlot_d = is_in_delayslot_i;
      if (excCode != 32'h0) begin
        flush_d = 1'b1;
        newPc_d = (excCode == 32'he) ? epcEff : EXC_VECTOR;
        state_d = SQUASH;
      end
    end
  end

  // State and registered outputs; reset wins over any exception in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      excType_q   <= 32'h0;
      instAddr_q  <= '0;
      delaySlot_q <= 1'b0;
      flush_q     <= 1'b0;
      newPc_q     <= '0;
    end else begin
      state_q     <= state_d;
      excType_q   <= excType_d;
      instAddr_q  <= instAddr_d;
      delaySlot_q <= delaySlot_d;
      flush_q     <= flush_d;
      newPc_q     <= newPc_d;
    end
  end

  assign excepttype_o        = excType_q;
  assign current_inst_addr_o = instAddr_q;
  assign is_in_delayslot_o   = delaySlot_q;
  assign flush_o             = flush_q;
  assign new_pc_o            = newPc_q;
  assign squash_o            = (state_q == SQUASH);

  // Fields of the flag word and cp0 registers that play no part in arbitration.
  assign unusedInputs = ^{excepttype_i[31:13], excepttype_i[7:0],
                          statusEff[DW-1:16], statusEff[7:2],
                          causeEff[DW-1:16], causeEff[7:0]};

endmodule
